// File: rtl/tdes_pkg.sv
// Shared register offsets, core-control states and the latched AHB
// address-phase record for the TDES slave front end.
package tdes_pkg;

  localparam logic [3:0] OFS_MODE   = 4'h0;
  localparam logic [3:0] OFS_KEY1   = 4'h1;
  localparam logic [3:0] OFS_KEY2   = 4'h2;
  localparam logic [3:0] OFS_KEY3   = 4'h3;
  localparam logic [3:0] OFS_DATA   = 4'h4;
  localparam logic [3:0] OFS_RESULT = 4'h8;
  localparam logic [3:0] OFS_STATUS = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } tdes_ctrl_state_t;

  // What the address phase decided; consumed during the following data phase.
  typedef struct packed {
    logic       valid;
    logic       write;
    logic [3:0] ofs;
  } ahb_xfer_t;

endpackage

// File: rtl/tdes_result_fifo.sv
// Circular result buffer between the TDES core and the bus read port.
// The caller guarantees no push when full and no pop when empty.
module tdes_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [63:0]            din,
  output logic [63:0]            dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array has no reset; occupancy lives only in the
  // pointers and count, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PTR_W + 1)'(DEPTH));

endmodule

// File: rtl/ahb_tdes_slave_if.sv
// AHB-Lite slave front end for the TDES core: configuration registers,
// start-pulse generation, result buffering and error signalling.
module ahb_tdes_slave_if #(
  parameter logic [27:0] BASE_ADDR  = 28'hAAAAAAA,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HADDR,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HRESP,
  output logic        enc_dec,
  output logic [63:0] key_one,
  output logic [63:0] key_two,
  output logic [63:0] key_three,
  output logic [63:0] data_in,
  output logic        data_in_valid,
  input  logic [63:0] result,
  input  logic        result_valid
);

  import tdes_pkg::*;

  ahb_xfer_t        xfer_q;
  tdes_ctrl_state_t state_q;
  tdes_ctrl_state_t state_d;

  logic             busy;
  logic             cfg_we;
  logic             data_accept;
  logic             fifo_push;
  logic             fifo_pop;
  logic [63:0]      fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic [63:0]      status_word;

  logic unused_inputs;
  assign unused_inputs = ^{HTRANS, HBURST, HSIZE, HPROT, HMASTLOCK};

  assign busy          = (state_q != IDLE);
  assign data_in_valid = (state_q == ISSUE);
  assign fifo_push     = (state_q == BUSY) && result_valid;

  tdes_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk   (HCLK),
    .rst_n (HRESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (result),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    status_word              = '0;
    status_word[0]           = fifo_empty;
    status_word[1]           = busy;
    status_word[2 +: CNT_W]  = fifo_count;
  end

  // Data-phase decode: response, read mux and the write/pop strobes that
  // take effect on the edge closing the data phase.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    HRDATA      = '0;
    HRESP       = 1'b0;
    cfg_we      = 1'b0;
    data_accept = 1'b0;
    fifo_pop    = 1'b0;
    if (xfer_q.valid) begin
      if (xfer_q.write) begin
        case (xfer_q.ofs)
          OFS_MODE, OFS_KEY1, OFS_KEY2, OFS_KEY3: begin
            if (busy) HRESP  = 1'b1;
            else      cfg_we = 1'b1;
          end
          OFS_DATA: begin
            if (!busy && !fifo_full) data_accept = 1'b1;
            else                     HRESP       = 1'b1;
          end
          default: HRESP = 1'b1;
        endcase
      end else begin
        case (xfer_q.ofs)
          OFS_MODE:   HRDATA = {63'b0, enc_dec};
          OFS_KEY1:   HRDATA = key_one;
          OFS_KEY2:   HRDATA = key_two;
          OFS_KEY3:   HRDATA = key_three;
          OFS_RESULT: begin
            if (fifo_empty) begin
              HRESP = 1'b1;
            end else begin
              HRDATA   = fifo_dout;
              fifo_pop = 1'b1;
            end
          end
          OFS_STATUS: HRDATA = status_word;
          default:    HRESP  = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      xfer_q    <= '0;
      enc_dec   <= 1'b0;
      key_one   <= '0;
      key_two   <= '0;
      key_three <= '0;
      data_in   <= '0;
    end else begin
      if (HSEL && HREADY && (HADDR[31:4] == BASE_ADDR))
        xfer_q <= '{valid: 1'b1, write: HWRITE, ofs: HADDR[3:0]};
      else
        xfer_q <= '0;

      if (cfg_we) begin
        case (xfer_q.ofs)
          OFS_MODE: enc_dec   <= HWDATA[0];
          OFS_KEY1: key_one   <= HWDATA;
          OFS_KEY2: key_two   <= HWDATA;
          default:  key_three <= HWDATA;
        endcase
      end

      if (data_accept) data_in <= HWDATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A single chunk is ever in flight, which is what keeps the FIFO from
  // overflowing: acceptance already required a free slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_accept) state_d = ISSUE;
      ISSUE:   state_d = BUSY;
      BUSY:    if (result_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ahb_tdes_slave_if.md
Name: ahb_tdes_slave_if

Overview:
- AHB-Lite slave front end for the Triple-DES datapath.
- Sits directly upstream of the TDES core. Decodes bus writes into the mode, three key and data-in registers, and issues one-cycle start pulses to the core.
- Downstream of the core, it buffers completed 64-bit chunks in a small result FIFO that the master drains by reading.
- Also exposes a read-only status word and flags illegal accesses on HRESP.

Parameters:
- BASE_ADDR, 28'hAAAAAAA: required value of HADDR[31:4] for a transfer to be selected.
- FIFO_DEPTH, 4: result FIFO entries; power of two, 2..16.
- CNT_W, $clog2(FIFO_DEPTH)+1: width of the occupancy counter.

Ports:
- HCLK  in  1  bus/system clock, all logic on rising edge.
- HRESET  in  1  synchronous, active-low reset.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready; a transfer is accepted only when HSEL && HREADY.
- HWRITE  in  1  1 = write, 0 = read.
- HTRANS  in  2  ignored.
- HBURST  in  3  ignored.
- HSIZE  in  3  ignored; always a 64-bit transfer.
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HADDR  in  32  byte address; HADDR[3:0] is the register offset.
- HWDATA  in  64  write data, sampled in the data phase.
- HRDATA  out  64  read data, valid in the data phase.
- HRESP  out  1  1 = error for the current data-phase transfer.
- enc_dec  out  1  mode to core; 1 = encrypt.
- key_one  out  64  key to core.
- key_two  out  64  key to core.
- key_three  out  64  key to core.
- data_in  out  64  chunk to core.
- data_in_valid  out  1  one-cycle start pulse to core.
- result  in  64  core output chunk.
- result_valid  in  1  one-cycle pulse; result is valid.

Behaviour:
- Reset:
  - HRESET low at a rising edge clears all registers, empties the FIFO and sets the FSM to IDLE.
  - Every output is 0 after reset, including HRDATA, HRESP and data_in_valid.
  - Reset mid-operation abandons the in-flight chunk. A result_valid pulse that arrives afterwards is ignored.
- Address phase:
  - On a rising edge where HSEL && HREADY && HADDR[31:4]==BASE_ADDR, latch {write, offset}.
  - Otherwise, latch "no transfer".
  - The data phase is the following cycle. Back-to-back transfers are pipelined with no wait states.
- Register map:
  - 0x0: mode, RW; bit0 = enc_dec.
  - 0x1: key_one, RW.
  - 0x2: key_two, RW.
  - 0x3: key_three, RW.
  - 0x4: data_in, write-only.
  - 0x8: result pop, read-only.
  - 0x9: status, read-only; bit0 fifo_empty, bit1 busy, bits[8:2] count zero-extended.
- Data-phase write:
  - Register captures HWDATA at the end of the data phase.
  - A write to 0x0–0x3 while busy (FSM not IDLE) is rejected.
- Write to 0x4:
  - Accepted only when FSM==IDLE and count < FIFO_DEPTH.
  - On acceptance, data_in loads and the FSM goes to ISSUE.
  - Otherwise it is rejected.
- Reads:
  - HRDATA is driven combinationally from the latched offset during the data phase, and is 0 when there is no read.
  - Reading 0x8 returns the FIFO head and pops on that edge.
  - Reading 0x8 when the FIFO is empty returns 0 with HRESP=1; no pop occurs.
- Errors:
  - Any rejected write, a read of 0x4, a write to 0x8 or 0x9, or an unmapped offset sets HRESP=1 for that single data-phase cycle.
  - No register or FIFO changes on an error.
- Core FSM:
  - IDLE -> ISSUE on an accepted 0x4 write.
  - ISSUE: data_in_valid=1 for exactly one cycle, then -> BUSY.
  - BUSY: on result_valid, push result into the FIFO and -> IDLE.
  - result_valid outside BUSY is ignored.
  - busy = (FSM != IDLE).
- FIFO:
  - Circular read and write pointers that wrap at FIFO_DEPTH.
  - Pop and push on the same edge leaves count unchanged; data ordering is preserved.
  - Overflow is impossible because a 0x4 write requires count < DEPTH and at most one chunk is in flight.
- Latency:
  - 0x4 data phase at edge N.
  - data_in_valid high in cycle N+1.
  - The result becomes readable on the cycle after result_valid.

Decomposition:
- tdes_pkg:
  - Offset localparams: OFS_MODE, OFS_KEY1, OFS_KEY2, OFS_KEY3, OFS_DATA, OFS_RESULT, OFS_STATUS.
  - typedef enum logic [1:0] {IDLE, ISSUE, BUSY} tdes_ctrl_state_t.
- Sub-module tdes_result_fifo:
  - Ports: push, pop, din, dout, count, empty, full; parameter DEPTH.
  - Instantiated once.

Test Plan:
- Reset, then write 0x0=1, 0x1=64'h1111111111111111, 0x2=64'h2222222222222222, 0x3=64'h3333333333333333 -> enc_dec=1 and keys match; HRESP=0 throughout.
- Write 0x4=64'hFFFFFFFFFFFFFFFF -> data_in_valid pulses exactly once, on the cycle after the data phase; status bit1=1. Model returns 64'hDEADBEEF00000001 -> status = {count=1, busy=0, empty=0}; read 0x8 returns 64'hDEADBEEF00000001; status is then empty.
- Write 0x4 while BUSY, and write 0x2 while BUSY -> HRESP=1 for one cycle; data_in and key_two unchanged.
- Fill with 4 chunks (64'h4444…, 64'h5555…, 64'h6666…, 64'h7777…), no reads -> the fifth 0x4 write (64'h8888…) is rejected with HRESP=1. Then read 4 times -> the four results in order; a fifth read returns 0 with HRESP=1.
- Read 0x8 in the same cycle that result_valid pushes (count=2) -> count stays 2 and the head is correct.
- Assert HRESET low while BUSY, then drive result_valid -> FIFO stays empty, all outputs are 0, and the next 0x4 write is accepted.
